// File: rtl/parity_gen_checker.sv
// parity_gen_checker: registered even/odd parity generator and checker for a
// DATA_W-bit word plus one received parity bit, with a sticky error flag.
// One-cycle latency from an accepted sample to valid_out.
// Optional feature: define PARITY_ERR_CNT_EN to build saturating even/odd
// error counters; when undefined the counter ports are tied to zero.
module parity_gen_checker #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              clr,
  output logic              valid_out,
  output logic              even_parity_gen,
  output logic              odd_parity_gen,
  output logic              even_parity_error,
  output logic              odd_parity_error,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  even_err_cnt,
  output logic [CNT_W-1:0]  odd_err_cnt
);

  logic w_p;
  logic w_even_err;

  logic r_valid;
  logic r_even_gen;
  logic r_odd_gen;
  logic r_even_err;
  logic r_odd_err;
  logic r_sticky;

  assign w_p        = ^data_in;
  assign w_even_err = w_p ^ parity_in;

  // Capture parity results on accepted samples; hold them otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_even_gen <= 1'b0;
      r_odd_gen  <= 1'b0;
      r_even_err <= 1'b0;
      r_odd_err  <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_even_gen <= w_p;
        r_odd_gen  <= ~w_p;
        r_even_err <= w_even_err;
        r_odd_err  <= ~w_even_err;
      end
    end
  end

  // Sticky error flag; clear takes priority over a same-cycle error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (clr) begin
      r_sticky <= 1'b0;
    end else if (valid_in && w_even_err) begin
      r_sticky <= 1'b1;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_even_cnt;
  logic [CNT_W-1:0] r_odd_cnt;

  // Saturating error counters; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (clr) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (valid_in) begin
      if (w_even_err && (r_even_cnt != CNT_MAX)) begin
        r_even_cnt <= r_even_cnt + CNT_W'(1);
      end
      if (!w_even_err && (r_odd_cnt != CNT_MAX)) begin
        r_odd_cnt <= r_odd_cnt + CNT_W'(1);
      end
    end
  end

  assign even_err_cnt = r_even_cnt;
  assign odd_err_cnt  = r_odd_cnt;
`else
  assign even_err_cnt = '0;
  assign odd_err_cnt  = '0;
`endif

  assign valid_out         = r_valid;
  assign even_parity_gen   = r_even_gen;
  assign odd_parity_gen    = r_odd_gen;
  assign even_parity_error = r_even_err;
  assign odd_parity_error  = r_odd_err;
  assign err_sticky        = r_sticky;

endmodule

// File: tb/tb_parity_gen_checker.sv
// Self-checking bench for parity_gen_checker: directed test-plan vectors,
// clear/hold behaviour, randomized back-to-back traffic and counter saturation,
// all checked against a behavioural model built from counts of ones.
module tb_parity_gen_checker;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              parity_in;
  logic              clr;
  logic              valid_out;
  logic              even_parity_gen;
  logic              odd_parity_gen;
  logic              even_parity_error;
  logic              odd_parity_error;
  logic              err_sticky;
  logic [CNT_W-1:0]  even_err_cnt;
  logic [CNT_W-1:0]  odd_err_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic m_valid, m_eg, m_og, m_ee, m_oe, m_sticky;
  int   m_ecnt, m_ocnt;

  parity_gen_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .parity_in         (parity_in),
    .clr               (clr),
    .valid_out         (valid_out),
    .even_parity_gen   (even_parity_gen),
    .odd_parity_gen    (odd_parity_gen),
    .even_parity_error (even_parity_error),
    .odd_parity_error  (odd_parity_error),
    .err_sticky        (err_sticky),
    .even_err_cnt      (even_err_cnt),
    .odd_err_cnt       (odd_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] got_vec();
    return {valid_out, even_parity_gen, odd_parity_gen,
            even_parity_error, odd_parity_error, err_sticky};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_valid, m_eg, m_og, m_ee, m_oe, m_sticky};
  endfunction

  // Apply one cycle of inputs, clock it, then advance the model.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic p, input logic c);
    int ones;
    rst = r; valid_in = v; data_in = d; parity_in = p; clr = c;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_eg = 0; m_og = 0; m_ee = 0; m_oe = 0; m_sticky = 0;
      m_ecnt = 0; m_ocnt = 0;
    end else begin
      m_valid = v;
      ones = $countones(d) + int'(p);
      if (v) begin
        m_eg = 1'($countones(d) % 2);
        m_og = !m_eg;
        m_ee = 1'(ones % 2);
        m_oe = !m_ee;
      end
      if (c) m_sticky = 0;
      else if (v && (ones % 2 == 1)) m_sticky = 1;
`ifdef PARITY_ERR_CNT_EN
      if (c) begin
        m_ecnt = 0; m_ocnt = 0;
      end else if (v) begin
        if (ones % 2 == 1) m_ecnt = (m_ecnt < CNT_MAX) ? m_ecnt + 1 : m_ecnt;
        else               m_ocnt = (m_ocnt < CNT_MAX) ? m_ocnt + 1 : m_ocnt;
      end
`endif
    end
  endtask

  task automatic test_reset();
    step(1, 1, 3'b111, 1, 1);
    step(1, 1, 3'b010, 0, 0);
    step(0, 0, 3'b000, 0, 0);
    checks++;
    if (got_vec() !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", got_vec(), 6'b000000);
    end
    checks++;
    if (even_err_cnt !== '0 || odd_err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", even_err_cnt, odd_err_cnt);
    end
  endtask

  task automatic test_directed();
    logic [DATA_W-1:0] d_tab [7] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b111, 3'b111, 3'b010};
    logic              p_tab [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0]        e_tab [7] = '{6'b101010, 6'b101101, 6'b101011, 6'b101101,
                                     6'b110011, 6'b110101, 6'b110101};
    for (int i = 0; i < 7; i++) begin
      step(0, 1, d_tab[i], p_tab[i], 0);
      checks++;
      if (got_vec() !== e_tab[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %b expected %b", i, got_vec(), e_tab[i]);
      end
    end
    checks++;
`ifdef PARITY_ERR_CNT_EN
    if (int'(even_err_cnt) !== 4 || int'(odd_err_cnt) !== 3) begin
      errors++;
      $display("FAIL directed_counters: got %0d/%0d expected 4/3", even_err_cnt, odd_err_cnt);
    end
`else
    if (even_err_cnt !== '0 || odd_err_cnt !== '0) begin
      errors++;
      $display("FAIL directed_counters: got %0d/%0d expected 0/0", even_err_cnt, odd_err_cnt);
    end
`endif
  endtask

  task automatic test_clr_hold();
    step(0, 1, 3'b001, 0, 1);   // erroring sample with clr: clr wins
    checks++;
    if (got_vec() !== 6'b110100) begin
      errors++;
      $display("FAIL clr_same_cycle: got %b expected %b", got_vec(), 6'b110100);
    end
    checks++;
    if (even_err_cnt !== '0 || odd_err_cnt !== '0) begin
      errors++;
      $display("FAIL clr_counters: got %0d/%0d expected 0/0", even_err_cnt, odd_err_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
      checks++;
      if (got_vec() !== 6'b010100) begin
        errors++;
        $display("FAIL hold_%0d: got %b expected %b", i, got_vec(), 6'b010100);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
      checks++;
      if (got_vec() !== exp_vec() || int'(even_err_cnt) !== m_ecnt
          || int'(odd_err_cnt) !== m_ocnt) begin
        errors++;
        $display("FAIL random_%0d: got %b %0d/%0d expected %b %0d/%0d", i,
                 got_vec(), even_err_cnt, odd_err_cnt, exp_vec(), m_ecnt, m_ocnt);
      end
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 3'b000, 0, 1);
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(0, 1, 3'b100, 0, 0);
      checks++;
      if (int'(even_err_cnt) !== m_ecnt || int'(odd_err_cnt) !== m_ocnt
          || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturate_%0d: got %b %0d/%0d expected %b %0d/%0d", i,
                 got_vec(), even_err_cnt, odd_err_cnt, exp_vec(), m_ecnt, m_ocnt);
      end
    end
    for (int i = 0; i < CNT_MAX + 2; i++) step(0, 1, 3'b100, 1, 0);
    checks++;
`ifdef PARITY_ERR_CNT_EN
    if (int'(even_err_cnt) !== CNT_MAX || int'(odd_err_cnt) !== CNT_MAX) begin
      errors++;
      $display("FAIL saturate_both: got %0d/%0d expected %0d/%0d",
               even_err_cnt, odd_err_cnt, CNT_MAX, CNT_MAX);
    end
`else
    if (even_err_cnt !== '0 || odd_err_cnt !== '0) begin
      errors++;
      $display("FAIL saturate_both: got %0d/%0d expected 0/0", even_err_cnt, odd_err_cnt);
    end
`endif
    step(0, 1, 3'b100, 0, 1);
    checks++;
    if (even_err_cnt !== '0 || odd_err_cnt !== '0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL saturate_clr: got %0d/%0d sticky %b expected 0/0 sticky 0",
               even_err_cnt, odd_err_cnt, err_sticky);
    end
  endtask

  initial begin
    rst = 1; valid_in = 0; data_in = '0; parity_in = 0; clr = 0;
    m_valid = 0; m_eg = 0; m_og = 0; m_ee = 0; m_oe = 0; m_sticky = 0;
    m_ecnt = 0; m_ocnt = 0;
    test_reset();
    test_directed();
    test_clr_hold();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_gen_checker.md
Name: parity_gen_checker

Overview:
- Registered parity generator and checker for a W-bit data word plus one received parity bit.
- Produces even and odd parity for the word, and flags an even-parity or odd-parity error on the received bit.
- Sits on a narrow data path between the producer and the link/receiver logic; one result per accepted sample.

Parameters:
- DATA_W, 3, data word width (≥1); default bit order is data_in[2]=A, data_in[1]=B, data_in[0]=C.
- CNT_W, 16, width of the optional error counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  sample qualifier; data_in/parity_in are captured only when high.
- data_in  input  DATA_W  data word.
- parity_in  input  1  received parity bit accompanying data_in.
- valid_out  output  1  high for one cycle when the outputs below hold a new result.
- even_parity_gen  output  1  XOR of all data_in bits; makes the total count of ones even.
- odd_parity_gen  output  1  inverse of even_parity_gen.
- even_parity_error  output  1  high when data_in plus parity_in contains an odd number of ones.
- odd_parity_error  output  1  high when data_in plus parity_in contains an even number of ones.
- err_sticky  output  1  set by any sample with even_parity_error=1; cleared only by rst or clr.
- clr  input  1  synchronous clear of err_sticky and the counters.
- even_err_cnt  output  CNT_W  count of even-parity errors (optional feature).
- odd_err_cnt  output  CNT_W  count of odd-parity errors (optional feature).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs become 0, including odd_parity_gen, valid_out, err_sticky and both counters. rst has priority over clr and valid_in.
- Latency: exactly 1 cycle. When valid_in=1 at edge N, results appear after edge N and valid_out=1 for that cycle.
- p = XOR-reduce(data_in).
  - even_parity_gen = p; odd_parity_gen = ~p.
  - even_parity_error = p ^ parity_in; odd_parity_error = ~(p ^ parity_in).
  - Exactly one of the two error outputs is 1 on every valid result.
- valid_in=0: the four parity outputs hold their last values and valid_out=0.
- Back-to-back: valid_in high every cycle gives one result per cycle, with no bubbles.
- err_sticky: set on a capture whose even_parity_error is 1. clr clears it; clr and an erroring capture in the same cycle leave it 0 (clr wins).
- clr does not affect the parity outputs or valid_out.
- No X propagation: the design is fully synchronous with no latches.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- Defined:
  - even_err_cnt increments on each capture with even_parity_error=1.
  - odd_err_cnt increments on each capture with odd_parity_error=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - clr zeroes both; clr wins over a same-cycle increment.
- Undefined: both counter ports are tied to 0 and no counter registers exist.

Test Plan:
- rst=1 for 2 cycles, then release -> all outputs 0, valid_out=0.
- data_in=000, parity_in=0, valid_in=1 -> next cycle: even_gen=0, odd_gen=1, even_err=0, odd_err=1, valid_out=1.
- data_in=000, parity_in=1 -> even_err=1, odd_err=0, err_sticky=1; with PARITY_ERR_CNT_EN, even_err_cnt=1.
- data_in=101 with parity_in=0, then parity_in=1 -> first sample: even_gen=0, even_err=0. Second sample: even_err=1.
- data_in=111 with parity_in=1, then parity_in=0; then data_in=010, parity_in=0 -> even_gen=1, even_err=0, then even_err=1. The 010 sample gives even_gen=1, even_err=1, odd_err=0.
- clr and an erroring sample in the same cycle; valid_in=0 for 3 cycles -> err_sticky=0, counters 0, outputs held, valid_out=0. Counter at max with a further error -> value unchanged.
